// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two requesters share one 9-bit ALU through a round-robin
// arbiter. It has two pipeline stages: grant/capture, then execute/result.
// Each grant is a one-cycle pulse. A requester whose grant is currently high
// is masked from the next arbitration, so a req held through its own grant
// cycle is not granted twice.
// Handshake: reqN is a level that is held until gntN pulses. The operands are
// captured on the grant edge. The result appears one cycle after the grant,
// with c_valid high for exactly one cycle and c_id naming the owner.
module alu_share_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [8:0] c,
    output logic       c_valid,
    output logic       c_id,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);

    localparam logic [1:0] OP_PASS_A = 2'b00;
    localparam logic [1:0] OP_PASS_B = 2'b01;
    localparam logic [1:0] OP_ADD    = 2'b10;

    // Arbitration state
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       last_q, last_d;    // 1: requester 1 was granted most recently

    // Stage register holding the winner's operation
    logic       stg_valid_q, stg_valid_d;
    logic [1:0] stg_op_q, stg_op_d;
    logic [7:0] stg_a_q, stg_a_d;
    logic [7:0] stg_b_q, stg_b_d;
    logic       stg_id_q, stg_id_d;

    // Execute stage and counters
    logic [8:0] c_q, c_d;
    logic       c_valid_q, c_valid_d;
    logic       c_id_q, c_id_d;
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    logic       elig0, elig1;
    logic [8:0] a_ext, b_ext;

    // Round-robin arbitration: a requester is eligible only when it is not
    // holding the grant from the previous edge.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        last_d = last_q;
        elig0  = req0 & ~gnt0_q;
        elig1  = req1 & ~gnt1_q;
        if (en) begin
            if (elig0 && elig1) begin
                if (last_q) begin
                    gnt0_d = 1'b1;
                end else begin
                    gnt1_d = 1'b1;
                end
            end else if (elig0) begin
                gnt0_d = 1'b1;
            end else if (elig1) begin
                gnt1_d = 1'b1;
            end
        end
        if (gnt0_d) begin
            last_d = 1'b0;
        end else if (gnt1_d) begin
            last_d = 1'b1;
        end
    end

    // Capture the winner's operation. The operand fields hold when there is
    // no grant, so only stg_valid is meaningful then.
    always_comb begin
        stg_valid_d = gnt0_d | gnt1_d;
        stg_op_d    = stg_op_q;
        stg_a_d     = stg_a_q;
        stg_b_d     = stg_b_q;
        stg_id_d    = stg_id_q;
        if (gnt0_d) begin
            stg_op_d = op0;
            stg_a_d  = a0;
            stg_b_d  = b0;
            stg_id_d = 1'b0;
        end else if (gnt1_d) begin
            stg_op_d = op1;
            stg_a_d  = a1;
            stg_b_d  = b1;
            stg_id_d = 1'b1;
        end
    end

    // Execute the staged operation on 9-bit sign-extended operands. The
    // 9-bit sum or difference of two 8-bit signed values cannot overflow.
    always_comb begin
        a_ext     = {stg_a_q[7], stg_a_q};
        b_ext     = {stg_b_q[7], stg_b_q};
        c_valid_d = stg_valid_q;
        c_d       = c_q;
        c_id_d    = c_id_q;
        if (stg_valid_q) begin
            c_id_d = stg_id_q;
            case (stg_op_q)
                OP_PASS_A: c_d = a_ext;
                OP_PASS_B: c_d = b_ext;
                OP_ADD:    c_d = a_ext + b_ext;
                default:   c_d = a_ext - b_ext;
            endcase
        end
    end

    // Saturating grant counters, one per requester.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0_d && (cnt0_q != 8'hFF)) begin
            cnt0_d = cnt0_q + 8'd1;
        end
        if (gnt1_d && (cnt1_q != 8'hFF)) begin
            cnt1_d = cnt1_q + 8'd1;
        end
    end

    // State registers. Reset clears the whole pipeline, so an in-flight
    // operation is dropped. last_q is set so that requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            last_q      <= 1'b1;
            stg_valid_q <= 1'b0;
            stg_op_q    <= 2'b00;
            stg_a_q     <= 8'h00;
            stg_b_q     <= 8'h00;
            stg_id_q    <= 1'b0;
            c_q         <= 9'h000;
            c_valid_q   <= 1'b0;
            c_id_q      <= 1'b0;
            cnt0_q      <= 8'h00;
            cnt1_q      <= 8'h00;
        end else begin
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            last_q      <= last_d;
            stg_valid_q <= stg_valid_d;
            stg_op_q    <= stg_op_d;
            stg_a_q     <= stg_a_d;
            stg_b_q     <= stg_b_d;
            stg_id_q    <= stg_id_d;
            c_q         <= c_d;
            c_valid_q   <= c_valid_d;
            c_id_q      <= c_id_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign c       = c_q;
    assign c_valid = c_valid_q;
    assign c_id    = c_id_q;
    assign cnt0    = cnt0_q;
    assign cnt1    = cnt1_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl. A directed vector table covers the ALU
// function and the grant/result latency. Hand-written sequences cover
// contention, enable gating, reset mid-flight and counter saturation.
module tb_alu_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1;
  logic [8:0] c;
  logic       c_valid, c_id;
  logic [7:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp_c;
  } vec_t;

  vec_t vecs[10];
  logic [9:0] exp_q[$];   // {c_id, c}

  alu_share_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .c(c), .c_valid(c_valid), .c_id(c_id),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b; req0 = 1'b0;
    end else begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b; req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_g;
    logic [9:0] e;
    int pops;
    int n;

    vecs[0] = '{1'b0, 2'b10, 8'd100, 8'd27, 9'h07F};
    vecs[1] = '{1'b1, 2'b11, 8'h80,  8'h7F, 9'h101};
    vecs[2] = '{1'b0, 2'b10, 8'h7F,  8'h7F, 9'h0FE};
    vecs[3] = '{1'b0, 2'b01, 8'h03,  8'hFB, 9'h1FB};
    vecs[4] = '{1'b1, 2'b00, 8'hFF,  8'h00, 9'h1FF};
    vecs[5] = '{1'b1, 2'b10, 8'hCE,  8'h14, 9'h1E2};
    vecs[6] = '{1'b0, 2'b11, 8'h05,  8'h0A, 9'h1FB};
    vecs[7] = '{1'b1, 2'b01, 8'h00,  8'h7F, 9'h07F};
    vecs[8] = '{1'b0, 2'b00, 8'h80,  8'h00, 9'h180};
    vecs[9] = '{1'b1, 2'b11, 8'h64,  8'h9C, 9'h0C8};

    // reset state
    rst = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_c", c, 0);
    check("rst_c_valid", c_valid, 0);
    check("rst_c_id", c_id, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    tick();
    rst = 1'b0;
    en = 1'b1;

    // table: single operations from idle
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      check("vec_gnt_win", vecs[i].id ? gnt1 : gnt0, 1);
      check("vec_gnt_other", vecs[i].id ? gnt0 : gnt1, 0);
      check("vec_c_valid_early", c_valid, 0);
      tick();
      check("vec_no_dup_gnt", gnt0 | gnt1, 0);
      check("vec_c_valid", c_valid, 1);
      check("vec_c", c, vecs[i].exp_c);
      check("vec_c_id", c_id, vecs[i].id);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check("vec_c_valid_drop", c_valid, 0);
      check("vec_c_hold", c, vecs[i].exp_c);
    end

    // contention from reset: continuous requests alternate 0,1,0,1
    do_reset();
    en = 1'b1;
    op0 = 2'b10; a0 = 8'd1; b0 = 8'd1;
    op1 = 2'b00; a1 = 8'd7; b1 = 8'd0;
    req0 = 1'b1; req1 = 1'b1;
    pops = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (c_valid) begin
        if (exp_q.size() == 0) begin
          check("cont_unexpected_c_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cont_result", {c_id, c}, e);
          pops++;
        end
      end
      if (i < 8) begin
        exp_g = i[0];
        check("cont_gnt0", gnt0, !exp_g);
        check("cont_gnt1", gnt1, exp_g);
        exp_q.push_back({exp_g, exp_g ? 9'd7 : 9'd2});
      end else begin
        check("cont_idle_gnt", gnt0 | gnt1, 0);
      end
      if (i == 7) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    check("cont_pops", pops, 8);
    check("cont_cnt0", cnt0, 4);
    check("cont_cnt1", cnt1, 4);

    // gating: en=0 blocks grants
    en = 1'b0; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_gnt", {gnt0, gnt1}, 0);
      check("gate_c_valid", c_valid, 0);
    end
    // en drops the cycle after a grant: the result still appears
    req0 = 1'b0; en = 1'b1;
    op1 = 2'b10; a1 = 8'hFD; b1 = 8'hFC;
    tick();
    check("gate_gnt1", gnt1, 1);
    en = 1'b0; req1 = 1'b0;
    tick();
    check("gate_late_c_valid", c_valid, 1);
    check("gate_late_c", c, 9'h1F9);
    check("gate_late_c_id", c_id, 1);
    tick();
    check("gate_late_drop", c_valid, 0);

    // reset pulsed in the gnt1 cycle
    do_reset();
    en = 1'b1; req0 = 1'b1; req1 = 1'b1;
    tick();
    check("mid_gnt0", gnt0, 1);
    tick();
    check("mid_gnt1", gnt1, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_gnt1", gnt1, 0);
    check("mid_rst_c_valid", c_valid, 0);
    check("mid_rst_c", c, 0);
    check("mid_rst_cnt0", cnt0, 0);
    check("mid_rst_cnt1", cnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_c_valid", c_valid, 0);
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("mid_next_gnt0", gnt0, 1);
    check("mid_next_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;

    // saturation: 300 grants to requester 0
    do_reset();
    en = 1'b1; req0 = 1'b1;
    n = 0;
    for (int i = 0; i < 1000 && n < 300; i++) begin
      tick();
      if (gnt0) begin
        n++;
        if (n == 10) check("sat_cnt0_10", cnt0, 10);
        if (n == 255) check("sat_cnt0_255", cnt0, 255);
      end
    end
    req0 = 1'b0;
    check("sat_grants", n, 300);
    tick();
    tick();
    check("sat_cnt0_hold", cnt0, 255);
    check("sat_cnt1", cnt1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
